// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_pkg
// Description : Shared definitions for the off-chip line memory responder.
//               Also imported by the data-cache controller for the line
//               geometry constants.
// Contents    : state_e          - responder FSM encoding (2-bit)
//               MEM_LINE_W       - cache line width in bits
//               MEM_OFFSET_BITS  - byte-offset bits below the line index
//               clog2()          - ceiling log2 for index/counter widths
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int MEM_LINE_W      = 256;
    localparam int MEM_OFFSET_BITS = 5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Fixed-latency main-memory responder for 256-bit cache lines.
//               A request is latched when enable_i is seen in IDLE; the
//               access is performed on the edge entering RESP, and ack_o is
//               high for exactly that one RESP cycle.
// Ports       : clk_i     in   clock, rising edge
//               rst_i     in   asynchronous reset, active low
//               addr_i    in   [31:0] byte address of the line
//               data_i    in   [LINE_W-1:0] write line data
//               enable_i  in   request valid, held until ack_o
//               write_i   in   1 = write line, 0 = read line
//               ack_o     out  one-cycle completion pulse
//               data_o    out  [LINE_W-1:0] read data, held until next read
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int LATENCY     = 10,
    parameter int LINE_W      = MEM_LINE_W,
    parameter int OFFSET_BITS = MEM_OFFSET_BITS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int IDX_W = (clog2(DEPTH)   > 0) ? clog2(DEPTH)   : 1;
    localparam int CNT_W = (clog2(LATENCY) > 0) ? clog2(LATENCY) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    req_idx_q, req_idx_d;
    logic                req_wr_q, req_wr_d;
    logic [LINE_W-1:0]   req_data_q, req_data_d;
    logic [LINE_W-1:0]   data_q;

    logic [LINE_W-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]    w_in_idx;
    logic                w_go_resp;
    logic [IDX_W-1:0]    w_op_idx;
    logic                w_op_wr;
    logic [LINE_W-1:0]   w_op_data;
    logic                w_mem_we;
    logic                w_unused_addr;

    // Upper address bits wrap the index; offset bits select within the line.
    assign w_in_idx      = addr_i[OFFSET_BITS +: IDX_W];
    assign w_unused_addr = ^addr_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_idx_d  = req_idx_q;
        req_wr_d   = req_wr_q;
        req_data_d = req_data_q;
        w_go_resp  = 1'b0;
        w_op_idx   = req_idx_q;
        w_op_wr    = req_wr_q;
        w_op_data  = req_data_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    req_idx_d  = w_in_idx;
                    req_wr_d   = write_i;
                    req_data_d = data_i;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-cycle build: the accept edge is also the
                        // access edge, so the live inputs drive the array.
                        state_d   = ST_RESP;
                        w_go_resp = 1'b1;
                        w_op_idx  = w_in_idx;
                        w_op_wr   = write_i;
                        w_op_data = data_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The counter hits zero on the same edge that enters RESP.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_RESP;
                    w_go_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_idx_q  <= '0;
            req_wr_q   <= 1'b0;
            req_data_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_idx_q  <= req_idx_d;
            req_wr_q   <= req_wr_d;
            req_data_q <= req_data_d;
            if (w_go_resp && !w_op_wr) begin
                data_q <= mem_q[w_op_idx];
            end
        end
    end

    // Storage has no reset; writes are blocked while reset is asserted so an
    // interrupted request can never commit.
    assign w_mem_we = rst_i && w_go_resp && w_op_wr;

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            mem_q[w_op_idx] <= w_op_data;
        end
    end

    assign ack_o  = (state_q == ST_RESP);
    assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory. Unit 0 is the default
//               build (DEPTH 512, LATENCY 10); unit 1 is a DEPTH 16,
//               LATENCY 1 build. Expected read data comes from a line model
//               and is queued at request time, then compared at ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en   [2];
    logic          wr   [2];
    logic [31:0]   addr [2];
    logic [LW-1:0] din  [2];
    logic [LW-1:0] dout [2];
    logic          ack  [2];

    always #5 clk = ~clk;

    data_memory #(.DEPTH(512), .LATENCY(10)) u_dut0 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .addr_i  (addr[0]),
        .data_i  (din[0]),
        .enable_i(en[0]),
        .write_i (wr[0]),
        .ack_o   (ack[0]),
        .data_o  (dout[0])
    );

    data_memory #(.DEPTH(16), .LATENCY(1)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .addr_i  (addr[1]),
        .data_i  (din[1]),
        .enable_i(en[1]),
        .write_i (wr[1]),
        .ack_o   (ack[1]),
        .data_o  (dout[1])
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [LW-1:0] exp_q [$];
    logic [LW-1:0] model [int];
    logic [LW-1:0] last_rd [2];

    function automatic int depth_of(input int u);
        return (u == 0) ? 512 : 16;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 10 : 1;
    endfunction

    function automatic int key_of(input int u, input logic [31:0] a);
        return u * 4096 + int'((a >> 5) % depth_of(u));
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_ack(input int u, input int start, output int n);
        n = start;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack[u] && n < 64);
        check("ack_seen", LW'(ack[u]), LW'(1));
    endtask

    // Full request: queue expectation, drive, wait for ack, compare, idle.
    task automatic do_req(input int u, input logic [31:0] a, input logic w,
                          input logic [LW-1:0] d, input string tag);
        int            n;
        logic [LW-1:0] e;
        e = w ? last_rd[u] : model[key_of(u, a)];
        exp_q.push_back(e);
        en[u] = 1'b1; addr[u] = a; wr[u] = w; din[u] = d;
        wait_ack(u, 0, n);
        en[u] = 1'b0;
        check({tag, "_lat"}, LW'(n), LW'(lat_of(u)));
        check({tag, "_data"}, dout[u], exp_q.pop_front());
        if (w) model[key_of(u, a)] = d;
        else   last_rd[u] = e;
        @(posedge clk); #1;
        check({tag, "_ack_low"}, LW'(ack[u]), LW'(0));
    endtask

    initial begin : main
        int            n1, n2;
        logic [LW-1:0] pa, pb, pc, pp, pq, pr, ps, pt, pv;
        pa = {8{32'hA5A5_0001}}; pb = {8{32'hB0B0_0002}}; pc = {8{32'hC3C3_0003}};
        pp = {8{32'h1111_2222}}; pq = {8{32'h3333_4444}}; pr = {8{32'h5555_6666}};
        ps = {8{32'h7777_8888}}; pt = {8{32'h9999_AAAA}};
        for (int u = 0; u < 2; u++) begin
            en[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; din[u] = '0; last_rd[u] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack0", LW'(ack[0]), LW'(0));
        check("rst_data0", dout[0], '0);
        check("rst_ack1", LW'(ack[1]), LW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read
        do_req(0, 32'h0000_0400, 1'b1, {8{32'hDEADBEEF}}, "wr400");
        do_req(0, 32'h0000_0400, 1'b0, '0, "rd400");

        // Offset bits ignored, upper bits wrap
        do_req(0, 32'h0000_0420, 1'b1, pa, "wr420");
        do_req(0, 32'h0000_043F, 1'b0, '0, "rd43F");
        do_req(0, 32'h0000_4420, 1'b0, '0, "rd4420");

        // Back-to-back reads of lines 2 and 3 with enable held
        do_req(0, 32'h0000_0040, 1'b1, pb, "wr_l2");
        do_req(0, 32'h0000_0060, 1'b1, pc, "wr_l3");
        exp_q.push_back(pb);
        exp_q.push_back(pc);
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0040;
        wait_ack(0, 0, n1);
        check("b2b_lat1", LW'(n1), LW'(10));
        check("b2b_data1", dout[0], exp_q.pop_front());
        addr[0] = 32'h0000_0060;
        @(posedge clk); #1;
        check("b2b_no_double_ack", LW'(ack[0]), LW'(0));
        wait_ack(0, 0, n2);
        en[0] = 1'b0;
        check("b2b_spacing", LW'(n2 + 1), LW'(11));
        check("b2b_data2", dout[0], exp_q.pop_front());
        last_rd[0] = pc;
        @(posedge clk); #1;

        // Inputs changed during WAIT are ignored
        do_req(0, 32'h0000_00E0, 1'b1, pr, "wr_l7");
        exp_q.push_back(last_rd[0]);
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_00C0; din[0] = pp;
        repeat (3) begin @(posedge clk); #1; end
        addr[0] = 32'h0000_00E0; din[0] = pq; wr[0] = 1'b0;
        wait_ack(0, 3, n1);
        en[0] = 1'b0;
        check("chg_lat", LW'(n1), LW'(10));
        check("chg_data_unchanged", dout[0], exp_q.pop_front());
        model[key_of(0, 32'h0000_00C0)] = pp;
        @(posedge clk); #1;
        do_req(0, 32'h0000_00C0, 1'b0, '0, "chg_rd_l6");
        do_req(0, 32'h0000_00E0, 1'b0, '0, "chg_rd_l7");

        // Reset mid-WAIT discards the write
        do_req(0, 32'h0000_0100, 1'b1, ps, "wr_l8");
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0100; din[0] = pt;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst_ack", LW'(ack[0]), LW'(0));
        check("midrst_data", dout[0], '0);
        en[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk); #1;
        do_req(0, 32'h0000_0100, 1'b0, '0, "postrst_rd_l8");

        // LATENCY=1 build: alternating writes and reads, then re-read
        for (int i = 0; i < 4; i++) begin
            pv = {8{32'hC0DE_0000 + 32'(i)}};
            do_req(1, 32'(i * 32), 1'b1, pv, "l1_wr");
            do_req(1, 32'(i * 32), 1'b0, '0, "l1_rd");
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1, 32'(i * 32 + 7), 1'b0, '0, "l1_reread");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
